// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU-sharing arbiter and related shared-resource blocks.
package alu_arb_pkg;

    localparam int unsigned ALU_OP_W = 5;
    localparam int unsigned ALU_W    = 32;

    typedef enum logic {EMPTY, FULL} arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter  int unsigned N    = 2,
    localparam int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Scan ptr, ptr+1, ... wrapping at N; stop at the first valid request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = ID_W'((32'(ptr) + i) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between N_REQ requesters with a single
// response register; one accepted op per cycle, one cycle of latency.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [N_REQ-1:0][ALU_W-1:0]      req_a_i,
    input  logic [N_REQ-1:0][ALU_W-1:0]      req_b_i,
    input  logic [N_REQ-1:0][ALU_OP_W-1:0]   req_op_i,
    output logic [N_REQ-1:0]                 rsp_valid_o,
    input  logic [N_REQ-1:0]                 rsp_ready_i,
    output logic [ALU_W-1:0]                 rsp_result_o,
    output logic                             rsp_flag_o,
    output logic [ALU_W-1:0]                 alu_a_o,
    output logic [ALU_W-1:0]                 alu_b_o,
    output logic [ALU_OP_W-1:0]              alu_op_o,
    input  logic [ALU_W-1:0]                 alu_result_i,
    input  logic                             alu_flag_i,
    output logic                             busy_o,
    output logic [31:0]                      op_count_o
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            can_accept;
    logic            arb_en;
    logic            drain;
    logic            any_gnt;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;

    // Reset gates the arbiter so no ready leaks out while rst_ni is low.
    always_comb begin
        can_accept = (state_q == EMPTY) || rsp_ready_i[rsp_id_q];
        arb_en     = can_accept && rst_ni;
    end

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Operand mux, ready and next-state decode.
    always_comb begin
        any_gnt     = |gnt;
        req_ready_o = gnt;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = '0;
        drain       = (state_q == FULL) && rsp_ready_i[rsp_id_q];
        state_d     = state_q;
        if (any_gnt) begin
            alu_a_o  = req_a_i[gnt_idx];
            alu_b_o  = req_b_i[gnt_idx];
            alu_op_o = req_op_i[gnt_idx];
            state_d  = FULL;
        end else if (drain) begin
            state_d  = EMPTY;
        end
    end

    assign busy_o = (state_q == FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= EMPTY;
            ptr_q        <= '0;
            rsp_id_q     <= '0;
            rsp_valid_o  <= '0;
            rsp_result_o <= '0;
            rsp_flag_o   <= 1'b0;
            op_count_o   <= '0;
        end else begin
            state_q <= state_d;
            if (any_gnt) begin
                rsp_result_o <= alu_result_i;
                rsp_flag_o   <= alu_flag_i;
                rsp_id_q     <= gnt_idx;
                rsp_valid_o  <= gnt;
                ptr_q        <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
                op_count_o   <= op_count_o + 32'd1;
            end else if (drain) begin
                // Result and flag keep their last value; only valid drops.
                rsp_valid_o  <= '0;
            end
        end
    end

endmodule
